loop_nest_sequencer: RTL and testbench

- Controller that drives the fixed-point case datapath through its full (a, j, i) index space for one pass per start.
- Issues one index tuple per accepted handshake, tracks in-flight datapath work, and signals completion once every issued tuple has responded.
- Sits between the top-level start control and the fixed-point wrapper datapath.
- Supports abort with drain.

---
 rtl/loop_nest_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_loop_nest_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_nest_sequencer.sv
// loop_nest_sequencer: walks the (a, j, i) index space once per start, issuing
// one tuple per handshake, tracking in-flight work and pulsing done at pass end.
// Optional build macro SEQ_CYCLE_CNT_EN adds a 32-bit saturating busy-cycle
// counter on output cycle_cnt.
module loop_nest_sequencer #(
  parameter  int J       = 14,
  parameter  int I       = 7,
  parameter  int A       = 2,
  parameter  int MAX_OUT = 4,
  localparam int J_WIDTH = $clog2(J) + 1,
  localparam int I_WIDTH = $clog2(I) + 1,
  localparam int A_WIDTH = $clog2(A) + 1,
  localparam int O_WIDTH = $clog2(MAX_OUT) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               idx_valid,
  input  logic               idx_ready,
  output logic [A_WIDTH-1:0] idx_a,
  output logic [J_WIDTH-1:0] idx_j,
  output logic [I_WIDTH-1:0] idx_i,
  output logic               idx_first,
  output logic               idx_last,
  input  logic               resp_valid,
  output logic               busy,
  output logic               done,
  output logic               aborted,
`ifdef SEQ_CYCLE_CNT_EN
  output logic [31:0]        cycle_cnt,
`endif
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(I - 1);
  localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(J - 1);
  localparam logic [A_WIDTH-1:0] A_LAST = A_WIDTH'(A - 1);
  localparam logic [O_WIDTH-1:0] O_MAX  = O_WIDTH'(MAX_OUT);

  state_t             r_state;
  state_t             w_nextState;
  logic [A_WIDTH-1:0] r_a;
  logic [J_WIDTH-1:0] r_j;
  logic [I_WIDTH-1:0] r_i;
  logic [O_WIDTH-1:0] r_outstanding;
  logic               r_err;
  logic               r_aborted;

  logic w_canIssue;
  logic w_xfer;
  logic w_accept;
  logic w_abortTake;
  logic w_iWrap;
  logic w_jWrap;
  logic w_aWrap;
  logic w_isFirst;
  logic w_isLast;
  logic w_noneOut;

  // The outstanding limit only gates issue while walking the index space;
  // idx_ready never feeds back into idx_valid, so the handshake cannot loop.
  assign w_canIssue  = (r_state == ST_ISSUE) && (r_outstanding < O_MAX);
  assign w_xfer      = w_canIssue && idx_ready;
  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_abortTake = (r_state == ST_ISSUE) && abort;
  assign w_noneOut   = (r_outstanding == '0);

  assign w_iWrap   = (r_i == I_LAST);
  assign w_jWrap   = (r_j == J_LAST);
  assign w_aWrap   = (r_a == A_LAST);
  assign w_isLast  = w_iWrap && w_jWrap && w_aWrap;
  assign w_isFirst = (r_i == '0) && (r_j == '0) && (r_a == '0);

  assign idx_a = r_a;
  assign idx_j = r_j;
  assign idx_i = r_i;
  assign err   = r_err;

  // Hold the current controller state; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pick the next state: issue until the last tuple goes out or abort, then
  // wait for every in-flight response before the single DONE cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort || (w_xfer && w_isLast)) begin
          w_nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_noneOut) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Decode handshake and status outputs purely from registered state so
  // every output is glitch-free and zero while reset is held.
  always_comb begin
    idx_valid = 1'b0;
    idx_first = 1'b0;
    idx_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        idx_valid = w_canIssue;
        idx_first = w_isFirst;
        idx_last  = w_isLast;
        busy      = 1'b1;
      end
      ST_DRAIN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        done    = 1'b1;
        aborted = r_aborted;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Step the index tuple on each accepted transfer, i fastest then j then a;
  // a stalled tuple simply keeps its registered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_j <= '0;
      r_i <= '0;
    end else if (w_accept) begin
      r_a <= '0;
      r_j <= '0;
      r_i <= '0;
    end else if (w_xfer) begin
      if (w_iWrap) begin
        r_i <= '0;
        if (w_jWrap) begin
          r_j <= '0;
          if (w_aWrap) begin
            r_a <= '0;
          end else begin
            r_a <= r_a + A_WIDTH'(1);
          end
        end else begin
          r_j <= r_j + J_WIDTH'(1);
        end
      end else begin
        r_i <= r_i + I_WIDTH'(1);
      end
    end
  end

  // Count tuples in flight; a response with nothing outstanding is flagged
  // as an error and never lets the counter underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (w_xfer && !resp_valid) begin
      r_outstanding <= r_outstanding + O_WIDTH'(1);
    end else if (!w_xfer && resp_valid && !w_noneOut) begin
      r_outstanding <= r_outstanding - O_WIDTH'(1);
    end
  end

  // Sticky error for unexpected responses, cleared only by a new pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (resp_valid && w_noneOut) begin
      r_err <= 1'b1;
    end
  end

  // Remember that this pass was cut short so DONE can report it; the flag
  // is dropped as DONE hands back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aborted <= 1'b0;
    end else if (w_accept || (r_state == ST_DONE)) begin
      r_aborted <= 1'b0;
    end else if (w_abortTake) begin
      r_aborted <= 1'b1;
    end
  end

`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0] r_cycleCnt;

  assign cycle_cnt = r_cycleCnt;

  // Measure pass length in busy cycles, holding the result after done and
  // pinning at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycleCnt <= '0;
    end else if (w_accept) begin
      r_cycleCnt <= '0;
    end else if (busy && (r_cycleCnt != 32'hFFFF_FFFF)) begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
    end
  end
`else
  // Without the cycle counter the sequencer carries no extra state.
`endif

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// tb_loop_nest_sequencer: directed bench for loop_nest_sequencer covering
// ordering, backpressure, outstanding limit, abort, spurious response and
// reset mid-pass. Build with SEQ_CYCLE_CNT_EN defined to also check cycle_cnt.
module tb_loop_nest_sequencer;

  localparam int J       = 14;
  localparam int I       = 7;
  localparam int A       = 2;
  localparam int MAX_OUT = 4;
  localparam int TOTAL   = A * J * I;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       idx_valid;
  logic       idx_ready;
  logic [1:0] idx_a;
  logic [4:0] idx_j;
  logic [3:0] idx_i;
  logic       idx_first;
  logic       idx_last;
  logic       resp_valid;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       err;
`ifdef SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  logic       autoResp;
  logic [1:0] respPipe;

  loop_nest_sequencer #(
    .J       (J),
    .I       (I),
    .A       (A),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx_a      (idx_a),
    .idx_j      (idx_j),
    .idx_i      (idx_i),
    .idx_first  (idx_first),
    .idx_last   (idx_last),
    .resp_valid (resp_valid),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
`ifdef SEQ_CYCLE_CNT_EN
    .cycle_cnt  (cycle_cnt),
`endif
    .err        (err)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Tuple n in a/j/i order plus first/last flags, packed like obsTuple.
  function automatic logic [12:0] expTuple(input int n);
    return {2'(n / (J * I)), 5'((n / I) % J), 4'(n % I), (n == 0), (n == TOTAL - 1)};
  endfunction

  function automatic logic [12:0] obsTuple();
    return {idx_a, idx_j, idx_i, idx_first, idx_last};
  endfunction

  // Carry current inputs across one rising edge; the response model returns
  // one resp_valid two cycles after each transfer when autoResp is set.
  task automatic applyStimulus();
    logic xferNow;
    xferNow = idx_valid && idx_ready;
    @(posedge clk);
    #1;
    respPipe   = {respPipe[0], xferNow};
    resp_valid = autoResp && respPipe[1];
  endtask

  // One full unaborted pass with in-order and stall checks.
  task automatic runPass(input bit randomReady);
    int         n;
    int         nDone;
    int         busyBad;
    int         busyCycles;
    logic       stalled;
    logic [12:0] snap;
    n = 0; nDone = 0; busyBad = 0; busyCycles = 0;
    idx_ready = 1'b1;
    start     = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("pass_busy_after_start", 32'(busy), 32'd1);
    checkOutput("pass_err_cleared", 32'(err), 32'd0);
    for (int c = 0; c < 4000 && nDone == 0; c++) begin
      idx_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx_valid && idx_ready) begin
        checkOutput("pass_tuple", 32'(obsTuple()), 32'(expTuple(n)));
        n++;
      end
      stalled = idx_valid && !idx_ready;
      snap    = obsTuple();
      if (busy) busyCycles++;
      applyStimulus();
      if (stalled && idx_valid) checkOutput("pass_stall_hold", 32'(obsTuple()), 32'(snap));
      if (done) begin
        nDone++;
        checkOutput("pass_aborted", 32'(aborted), 32'd0);
      end else if (!busy) begin
        busyBad++;
      end
    end
    checkOutput("pass_xfer_count", 32'(n), 32'(TOTAL));
    checkOutput("pass_busy_until_done", 32'(busyBad), 32'd0);
`ifdef SEQ_CYCLE_CNT_EN
    checkOutput("pass_cycle_cnt", cycle_cnt, 32'(busyCycles));
`endif
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      if (done) nDone++;
    end
    checkOutput("pass_done_once", 32'(nDone), 32'd1);
    checkOutput("pass_idle_after", 32'({busy, idx_valid}), 32'd0);
  endtask

  // Directed scenario sequence.
  initial begin
    int   n;
    int   nResp;
    int   respEdge;
    int   doneEdge;
    int   lateValid;
    logic xferNow;
    logic respNow;
    logic found;

    rst = 1'b1; start = 1'b0; abort = 1'b0; idx_ready = 1'b0;
    resp_valid = 1'b0; autoResp = 1'b0; respPipe = 2'b00;
    #12;
    checkOutput("reset_flags", 32'({idx_valid, idx_first, idx_last, busy, done, aborted, err}), 32'd0);
    checkOutput("reset_indices", 32'({idx_a, idx_j, idx_i}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus();
    checkOutput("idle_no_start", 32'({busy, idx_valid}), 32'd0);

    $display("[TB] ordering pass");
    autoResp = 1'b1;
    runPass(1'b0);

    $display("[TB] backpressure pass");
    runPass(1'b1);

    $display("[TB] outstanding limit");
    autoResp = 1'b0; idx_ready = 1'b1;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx_valid && idx_ready) n++;
      applyStimulus();
    end
    checkOutput("limit_first_burst", 32'(n), 32'(MAX_OUT));
    checkOutput("limit_valid_low", 32'(idx_valid), 32'd0);
    resp_valid = 1'b1;
    applyStimulus();
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx_valid && idx_ready) n++;
      applyStimulus();
    end
    checkOutput("limit_one_more", 32'(n), 32'd1);
    checkOutput("limit_valid_low2", 32'(idx_valid), 32'd0);
    resp_valid = 1'b1;
    applyStimulus();
    checkOutput("limit_slot_freed", 32'(idx_valid), 32'd1);
    resp_valid = 1'b1;
    applyStimulus();
    checkOutput("limit_simul_hold", 32'(idx_valid), 32'd1);
    applyStimulus();
    checkOutput("limit_full_again", 32'(idx_valid), 32'd0);
    checkOutput("limit_no_err", 32'(err), 32'd0);
    rst = 1'b1;
    applyStimulus();
    respPipe = 2'b00; resp_valid = 1'b0;
    rst = 1'b0;

    $display("[TB] abort after 50 transfers");
    autoResp = 1'b1; idx_ready = 1'b1;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    n = 0; nResp = 0; respEdge = -1; doneEdge = -1; lateValid = 0;
    for (int c = 0; c < 600 && doneEdge < 0; c++) begin
      xferNow = idx_valid && idx_ready;
      if (n >= 50 && idx_valid) lateValid++;
      if (xferNow && n == 49) abort = 1'b1;
      if (xferNow) n++;
      respNow = resp_valid;
      if (respNow) nResp++;
      applyStimulus();
      abort = 1'b0;
      if (respNow && nResp == 50) respEdge = c;
      if (done) begin
        doneEdge = c;
        checkOutput("abort_flag", 32'(aborted), 32'd1);
      end
    end
    checkOutput("abort_xfers", 32'(n), 32'd50);
    checkOutput("abort_no_valid", 32'(lateValid), 32'd0);
    checkOutput("abort_resps", 32'(nResp), 32'd50);
    checkOutput("abort_done_latency", 32'(doneEdge - respEdge), 32'd1);
    applyStimulus();
    checkOutput("abort_flag_clears", 32'({done, aborted, busy}), 32'd0);

    $display("[TB] spurious response");
    autoResp = 1'b0;
    resp_valid = 1'b1;
    applyStimulus();
    checkOutput("spurious_err_set", 32'(err), 32'd1);
    for (int c = 0; c < 3; c++) applyStimulus();
    checkOutput("spurious_err_sticky", 32'(err), 32'd1);
    autoResp = 1'b1;
    runPass(1'b0);
    checkOutput("spurious_err_after_pass", 32'(err), 32'd0);

    $display("[TB] reset mid-pass");
    idx_ready = 1'b1;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      if (idx_valid && idx_a == 2'd1 && idx_j == 5'd5 && idx_i == 4'd3) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("rst_reached_1_5_3", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_flags", 32'({idx_valid, idx_first, idx_last, busy, done, aborted, err}), 32'd0);
    checkOutput("rst_async_indices", 32'({idx_a, idx_j, idx_i}), 32'd0);
    autoResp = 1'b0;
    applyStimulus();
    applyStimulus();
    respPipe = 2'b00; resp_valid = 1'b0;
    rst = 1'b0;
    autoResp = 1'b1;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("rst_restart_valid", 32'(idx_valid), 32'd1);
    checkOutput("rst_restart_tuple", 32'(obsTuple()), 32'(expTuple(0)));
    checkOutput("rst_restart_err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
